core_run_ctrl: RTL
==================

Name: core_run_ctrl

Overview:
Run/halt sequencer for the 5-stage RISC-V datapath.
- On `start`, holds the core in reset, then releases it.
- Counts cycles and retired instructions.
- Detects the halt idiom: a tight PC loop of length 1..HIST_DEPTH.
- Stops on halt or timeout, latching halt PC, loop length and performance counters for the SoC status interface.

Parameters:
HIST_DEPTH, 4, longest PC loop length detected (history entries).
LOOP_REPS, 2, match count per loop-length unit required to declare a halt (threshold = LOOP_REPS*k).
RST_CYCLES, 2, cycles core_rst_n is held low after start.
TIMEOUT_CYCLES, 2000, RUN cycles before forced stop.
NOP_INSTR, 32'h00000013, encoding excluded from instr_count.
CNT_W, 32, counter width.

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-low
start  input  1  begin a run (accepted in IDLE or DONE)
abort  input  1  cancel run, return to IDLE
core_pc  input  32  current PC from datapath
core_instr  input  32  current instruction from datapath
core_stall  input  1  datapath stall indication
core_rst_n  output  1  active-low reset to datapath
running  output  1  high in RESET_CORE and RUN
done  output  1  high in DONE
timeout  output  1  run ended by timeout (valid when done)
halt_pc  output  32  PC at halt detection
loop_len  output  3  detected loop length k (0 on timeout)
cycle_count  output  CNT_W  RUN cycles elapsed
instr_count  output  CNT_W  non-NOP, non-stalled RUN cycles

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE.
  - core_rst_n=0; running, done, timeout = 0; halt_pc, loop_len, cycle_count, instr_count = 0.
  - History, history-valid count and match counters are cleared.
- FSM states: IDLE, RESET_CORE, RUN, DONE. Outputs are registered.
- IDLE:
  - core_rst_n=0.
  - start=1 -> RESET_CORE next cycle.
- RESET_CORE (start accepted):
  - Counters, history, match counters, timeout, loop_len and halt_pc are cleared on entry.
  - core_rst_n=0 for RST_CYCLES cycles, then -> RUN.
  - core_rst_n=1 from the first RUN cycle.
- RUN, every cycle:
  - cycle_count += 1.
  - If core_instr != NOP_INSTR and core_stall=0: instr_count += 1.
- Loop detection in RUN:
  - Applies only on cycles with core_stall=0. On stalled cycles, history and match counters are frozen.
  - History hist[1..HIST_DEPTH] holds the PC of the last HIST_DEPTH non-stalled cycles. hist[k] is the PC k non-stalled cycles ago.
  - For each k, match counter m_k is evaluated only if the history-valid count >= k:
    - m_k += 1 if core_pc == hist[k]; otherwise m_k = 0.
    - For k=1, a match additionally requires core_instr to equal the previous non-stalled core_instr.
  - Halt when any m_k (post-update) >= LOOP_REPS*k:
    - Next cycle -> DONE.
    - halt_pc = core_pc of the detecting cycle; loop_len = smallest qualifying k.
  - Counters include the detecting cycle.
  - History shifts in core_pc after comparison.
- Timeout:
  - If a RUN cycle starts with cycle_count == TIMEOUT_CYCLES-1: after increment -> DONE, timeout=1, loop_len=0, halt_pc=core_pc.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DONE:
  - done=1; all results frozen.
  - core_rst_n stays 1, so the core keeps spinning and its register file stays readable.
  - start=1 -> RESET_CORE (new run).
- abort=1 in RESET_CORE or RUN:
  - Next state IDLE; core_rst_n=0; done=0.
  - Counters keep their values until the next start.
- Priority: abort > start. start in RUN or RESET_CORE is ignored.
- Reset mid-run overrides everything.
- Counters saturate at all-ones; they never wrap.
- running = state is RESET_CORE or RUN.

Test Plan:
1. Reset low 3 cycles, then high, with start=0 -> core_rst_n=0, running=0, done=0, all counters 0.
2. Single-instruction halt:
   - Stimulus: start; after RST_CYCLES, PC sequence 0x0, 0x4, 0x8, 0xC, 0x10, 0x10, 0x10, with constant non-NOP instr at 0x10 and no stall.
   - Response: done=1 the cycle after the 7th RUN cycle; loop_len=1, halt_pc=0x10, cycle_count=7, instr_count=7, timeout=0.
3. Two-instruction halt:
   - Stimulus: PCs 0x0, 0x4, 0x8, 0x4, 0x8, 0x4, 0x8.
   - Response: m_2 reaches 4 on the 7th RUN cycle; loop_len=2, halt_pc=0x8, cycle_count=7.
4. Stall immunity:
   - Stimulus: PC held at 0x20 with core_stall=1 for 10 cycles mid-run, non-NOP instr.
   - Response: no halt; cycle_count +10; instr_count unchanged; match counters unchanged.
5. Timeout:
   - Stimulus: TIMEOUT_CYCLES=16, PC incrementing by 4, some cycles with instr=0x00000013.
   - Response: done=1, timeout=1, loop_len=0, cycle_count=16, instr_count=16 minus number of NOP cycles.
6. Abort and restart:
   - Stimulus: abort at RUN cycle 5.
   - Response: next cycle IDLE, core_rst_n=0, done=0.
   - Stimulus: then start.
   - Response: counters read 0 during RESET_CORE; core_rst_n low for exactly RST_CYCLES cycles; a new run proceeds normally.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/halt sequencer for the 5-stage RISC-V datapath.
// Holds the core in reset after start, then lets it run while counting
// cycles and retired instructions. A run ends when the PC settles into a
// tight loop (the halt idiom) or when the cycle budget runs out. Results
// stay latched for the SoC status interface.
//
// Handshake: start and abort are level-sampled command strobes with no
// ready. start is taken only in IDLE or DONE; abort is taken only in
// RESET_CORE or RUN and beats start in the same cycle. All status outputs
// are registered and change only on the clock edge after the command.
module core_run_ctrl #(
  parameter int          HIST_DEPTH     = 4,
  parameter int          LOOP_REPS      = 2,
  parameter int          RST_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 2000,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013,
  parameter int          CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      core_pc,
  input  logic [31:0]      core_instr,
  input  logic             core_stall,
  output logic             core_rst_n,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      halt_pc,
  output logic [2:0]       loop_len,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [1:0]       state_dbg
);

  // Match counters only need to reach the largest threshold; they saturate.
  localparam int MATCH_MAX = LOOP_REPS * HIST_DEPTH;
  localparam int MW        = $clog2(MATCH_MAX + 1);
  localparam int HW        = $clog2(HIST_DEPTH + 1);
  localparam int RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_CORE = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_next;
  logic [RW-1:0] rst_cnt;

  // hist[k] is the PC seen k non-stalled RUN cycles ago.
  logic [31:0]   hist [1:HIST_DEPTH];
  logic [HW-1:0] hist_cnt;
  logic [31:0]   prev_instr;
  logic [MW-1:0] match_q    [1:HIST_DEPTH];
  logic [MW-1:0] match_next [1:HIST_DEPTH];

  logic          halt_hit;
  logic [2:0]    halt_k;
  logic          start_run;
  logic          run_cycle;
  logic          track;
  logic          halt_det;
  logic          timeout_hit;

  assign state_dbg = state_q;

  // A run begins only from a resting state, and abort always wins.
  assign start_run   = start && !abort && ((state_q == IDLE) || (state_q == DONE));
  // An aborted RUN cycle is not counted: the run is cancelled as of that edge.
  assign run_cycle   = (state_q == RUN) && !abort;
  // Loop tracking ignores stalled cycles entirely.
  assign track       = run_cycle && !core_stall;
  assign halt_det    = track && halt_hit;
  assign timeout_hit = run_cycle && (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Post-update match counters and the smallest loop length that qualifies.
  always_comb begin
    halt_hit = 1'b0;
    halt_k   = 3'd0;
    for (int k = 1; k <= HIST_DEPTH; k++) begin
      match_next[k] = match_q[k];
      if (int'(hist_cnt) >= k) begin
        // A one-instruction loop must also repeat the same instruction word.
        if ((core_pc == hist[k]) && ((k != 1) || (core_instr == prev_instr))) begin
          match_next[k] = (&match_q[k]) ? match_q[k] : match_q[k] + MW'(1);
        end else begin
          match_next[k] = '0;
        end
      end
    end
    // Scan from the longest loop down so the smallest qualifying k is kept.
    for (int k = HIST_DEPTH; k >= 1; k--) begin
      if (int'(match_next[k]) >= LOOP_REPS * k) begin
        halt_hit = 1'b1;
        halt_k   = 3'(k);
      end
    end
  end

  // Next-state logic; abort outranks halt, timeout and start.
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (start_run) state_next = RESET_CORE;
      end
      RESET_CORE: begin
        if (abort)                                 state_next = IDLE;
        else if (rst_cnt == RW'(RST_CYCLES - 1))   state_next = RUN;
      end
      RUN: begin
        if (abort)                        state_next = IDLE;
        else if (halt_det || timeout_hit) state_next = DONE;
      end
      DONE: begin
        if (start_run) state_next = RESET_CORE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Status outputs registered from the state being entered. core_rst_n stays
  // high in DONE so the core keeps spinning and its registers stay readable.
  always_ff @(posedge clock) begin
    if (!reset) begin
      core_rst_n <= 1'b0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      core_rst_n <= (state_next == RUN) || (state_next == DONE);
      running    <= (state_next == RESET_CORE) || (state_next == RUN);
      done       <= (state_next == DONE);
    end
  end

  // Length of the core reset phase.
  always_ff @(posedge clock) begin
    if (!reset || start_run)          rst_cnt <= '0;
    else if (state_q == RESET_CORE)   rst_cnt <= rst_cnt + RW'(1);
  end

  // Performance counters: cleared when a run is accepted, frozen outside RUN.
  always_ff @(posedge clock) begin
    if (!reset || start_run) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else if (run_cycle) begin
      cycle_count <= sat_inc(cycle_count);
      if (!core_stall && (core_instr != NOP_INSTR)) begin
        instr_count <= sat_inc(instr_count);
      end
    end
  end

  // PC history and match counters advance only on non-stalled RUN cycles.
  always_ff @(posedge clock) begin
    if (!reset || start_run) begin
      for (int k = 1; k <= HIST_DEPTH; k++) begin
        hist[k]    <= '0;
        match_q[k] <= '0;
      end
      hist_cnt   <= '0;
      prev_instr <= '0;
    end else if (track) begin
      hist[1] <= core_pc;
      for (int k = 2; k <= HIST_DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end
      for (int k = 1; k <= HIST_DEPTH; k++) begin
        match_q[k] <= match_next[k];
      end
      prev_instr <= core_instr;
      if (hist_cnt != HW'(HIST_DEPTH)) hist_cnt <= hist_cnt + HW'(1);
    end
  end

  // Run result latch; a halt in the timeout cycle is reported as a halt.
  always_ff @(posedge clock) begin
    if (!reset || start_run) begin
      timeout  <= 1'b0;
      halt_pc  <= '0;
      loop_len <= '0;
    end else if (halt_det) begin
      timeout  <= 1'b0;
      halt_pc  <= core_pc;
      loop_len <= halt_k;
    end else if (timeout_hit) begin
      timeout  <= 1'b1;
      halt_pc  <= core_pc;
      loop_len <= 3'd0;
    end
  end

endmodule
